// File: rtl/demux_1to8_dec.sv
// ---------------------------------------------------------------------------
// demux_1to8_dec
// Slot write-enable decoder for the serial capture block. Turns a binary slot
// index into a one-hot write enable. All enables are low when en is low, so
// no staging bit changes in that cycle.
//
// Ports:
//   sel  in   SEL_W  slot index to write
//   en   in   1      a bit is being accepted this cycle
//   we   out  N      one-hot write enable (all zero when en=0)
// ---------------------------------------------------------------------------
module demux_1to8_dec #(
   parameter int N     = 8,
   parameter int SEL_W = 3
) (
   input  logic [SEL_W-1:0] sel,
   input  logic             en,
   output logic [N-1:0]     we
);

   always_comb begin
      we = '0;
      if (en) begin
         we[sel] = 1'b1;
      end
   end

endmodule

// File: rtl/demux_1to8_capture.sv
// ---------------------------------------------------------------------------
// demux_1to8_capture
// Serial-to-parallel capture at the receive end of the mux-based serial link.
// Each accepted serial bit goes into one of N staging slots, chosen by an
// internal slot counter. When slot N-1 is filled, the whole word is moved
// into a registered output that uses a valid/ready handshake. A start bit
// aligns the counter to slot 0.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   din        in   1      serial data bit
//   din_valid  in   1      din is consumed this cycle (no backpressure)
//   start      in   1      din is slot 0 of a new frame (only when din_valid)
//   y          out  N      captured word; y[k] is the k-th bit after start
//   out_valid  out  1      y holds an unconsumed frame
//   out_ready  in   1      consumer takes y when out_valid & out_ready
//   sel        out  SEL_W  slot the next accepted bit is written to
//   overrun    out  1      pulse: completed frame lost because y was held
//   sync_err   out  1      pulse: start arrived with a partial frame pending
// ---------------------------------------------------------------------------
module demux_1to8_capture #(
   parameter int N     = 8,
   parameter int SEL_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din,
   input  logic             din_valid,
   input  logic             start,
   output logic [N-1:0]     y,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [SEL_W-1:0] sel,
   output logic             overrun,
   output logic             sync_err
);

   localparam logic IDLE = 1'b0;
   localparam logic RUN  = 1'b1;

   localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N - 1);

   logic             state_q,     state_d;
   logic [SEL_W-1:0] sel_q,       sel_d;
   logic [N-1:0]     staging_q,   staging_d;
   logic [N-1:0]     y_q,         y_d;
   logic             out_valid_q, out_valid_d;
   logic             overrun_q,   overrun_d;
   logic             sync_err_q,  sync_err_d;

   logic             accept;
   logic [SEL_W-1:0] wr_sel;
   logic [N-1:0]     we;
   logic             complete;

   // A bit is taken in RUN, or in IDLE only when it carries start. Start
   // always sends the bit to slot 0, whatever the counter holds.
   assign accept = din_valid & ((state_q == RUN) | start);
   assign wr_sel = start ? '0 : sel_q;

   demux_1to8_dec #(
      .N     (N),
      .SEL_W (SEL_W)
   ) u_dec (
      .sel (wr_sel),
      .en  (accept),
      .we  (we)
   );

   // Start forces slot 0, so a start bit can never complete a frame.
   assign complete = accept & (wr_sel == LAST_SLOT);

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      y_d         = y_q;
      out_valid_d = out_valid_q;
      overrun_d   = 1'b0;
      sync_err_d  = 1'b0;

      staging_d = (staging_q & ~we) | (we & {N{din}});

      if (accept) begin
         state_d = RUN;
         sel_d   = wr_sel + 1'b1;
      end

      if (din_valid && start && (state_q == RUN) && (sel_q != '0)) begin
         sync_err_d = 1'b1;
      end

      // staging_d already includes the final bit, so it is the completed word.
      if (complete) begin
         if (!out_valid_q || out_ready) begin
            y_d         = staging_d;
            out_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sel_q       <= '0;
         staging_q   <= '0;
         y_q         <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         sync_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         staging_q   <= staging_d;
         y_q         <= y_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
         sync_err_q  <= sync_err_d;
      end
   end

   assign y         = y_q;
   assign out_valid = out_valid_q;
   assign sel       = sel_q;
   assign overrun   = overrun_q;
   assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_demux_1to8_capture.sv
// ---------------------------------------------------------------------------
// tb_demux_1to8_capture
// Scoreboard bench. Stimulus pushes the hand-computed word that each frame
// should produce. A monitor pops and compares on every accepted output beat
// and also counts overrun and sync_err pulses.
// ---------------------------------------------------------------------------
module tb_demux_1to8_capture;

   localparam int N     = 8;
   localparam int SEL_W = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             din = 1'b0;
   logic             din_valid = 1'b0;
   logic             start = 1'b0;
   logic             out_ready = 1'b0;
   logic [N-1:0]     y;
   logic             out_valid;
   logic [SEL_W-1:0] sel;
   logic             overrun;
   logic             sync_err;

   int n_checks = 0;
   int n_fails  = 0;
   int overrun_seen  = 0;
   int sync_err_seen = 0;
   logic [N-1:0] exp_q[$];

   demux_1to8_capture #(.N(N), .SEL_W(SEL_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din),
      .din_valid (din_valid),
      .start     (start),
      .y         (y),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .sel       (sel),
      .overrun   (overrun),
      .sync_err  (sync_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Inputs change 1 time unit after the rising edge.
   task automatic send_bit(input logic b, input logic st);
      din       = b;
      start     = st;
      din_valid = 1'b1;
      @(posedge clk); #1;
      din_valid = 1'b0;
      start     = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      din_valid = 1'b0;
      start     = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Sends v LSB first. expect_out pushes v onto the scoreboard just before the
   // completing bit. gap_after adds one din_valid=0 cycle after that slot
   // (gap_after >= N means no gap).
   task automatic send_frame(input logic [N-1:0] v, input logic st, input logic expect_out,
                             input int gap_after);
      for (int k = 0; k < N; k++) begin
         if (k == N - 1 && expect_out) exp_q.push_back(v);
         send_bit(v[k], st && (k == 0));
         if (k == gap_after) idle_cycles(1);
      end
   endtask

   // Monitor: runs at the falling edge, midway between the input updates.
   initial begin
      logic [N-1:0] exp_y;
      forever begin
         @(negedge clk);
         if (overrun === 1'b1) overrun_seen++;
         if (sync_err === 1'b1) sync_err_seen++;
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fails++;
               $display("FAIL unexpected_beat: got y=0x%0h, expected no output", y);
            end else begin
               exp_y = exp_q.pop_front();
               check("beat_y", 32'(y), 32'(exp_y));
            end
         end
      end
   end

   initial begin
      int ov_base;
      int se_base;

      // Reset
      rst_n = 1'b0;
      #12;
      check("rst_y", 32'(y), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_sel", 32'(sel), 32'h0);
      check("rst_overrun", 32'(overrun), 32'h0);
      check("rst_sync_err", 32'(sync_err), 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: basic frame, slots 1,0,1,1,0,0,1,0 -> 0x4D
      out_ready = 1'b1;
      send_frame(8'h4D, 1'b1, 1'b1, N);
      check("t1_out_valid_after", 32'(out_valid), 32'h1);
      check("t1_y", 32'(y), 32'h4D);
      check("t1_sel_wrapped", 32'(sel), 32'h0);
      idle_cycles(1);
      check("t1_out_valid_one_cycle", 32'(out_valid), 32'h0);

      // 2: bits without start are ignored while unaligned
      rst_n = 1'b0; #2; rst_n = 1'b1;
      idle_cycles(1);
      for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0);
      check("t2_sel_idle", 32'(sel), 32'h0);
      check("t2_out_valid_idle", 32'(out_valid), 32'h0);
      send_frame(8'hFF, 1'b1, 1'b1, N);
      idle_cycles(2);

      // 3: back-to-back frames, start only on the first
      ov_base = overrun_seen;
      send_frame(8'hA5, 1'b1, 1'b1, N);
      send_frame(8'h3C, 1'b0, 1'b1, N);
      idle_cycles(2);
      check("t3_no_overrun", 32'(overrun_seen - ov_base), 32'h0);

      // 4: overrun while the output is held
      out_ready = 1'b0;
      ov_base = overrun_seen;
      send_frame(8'h11, 1'b1, 1'b1, N);
      send_frame(8'h22, 1'b0, 1'b0, N);
      idle_cycles(2);
      check("t4_y_held", 32'(y), 32'h11);
      check("t4_out_valid_held", 32'(out_valid), 32'h1);
      check("t4_overrun_once", 32'(overrun_seen - ov_base), 32'h1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("t4_out_valid_drop", 32'(out_valid), 32'h0);

      // 5: resync mid-frame, then an aligned start with sel==0
      se_base = sync_err_seen;
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_frame(8'hC3, 1'b1, 1'b1, N);
      idle_cycles(2);
      check("t5_sync_err_once", 32'(sync_err_seen - se_base), 32'h1);
      send_frame(8'h96, 1'b1, 1'b1, N);
      idle_cycles(2);
      check("t5_no_sync_err_aligned", 32'(sync_err_seen - se_base), 32'h1);

      // 6: asynchronous reset between edges, with a held frame pending
      out_ready = 1'b0;
      send_frame(8'h77, 1'b1, 1'b0, N);
      for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0);
      #3;
      rst_n = 1'b0;
      #1;
      check("t6_rst_y", 32'(y), 32'h0);
      check("t6_rst_out_valid", 32'(out_valid), 32'h0);
      check("t6_rst_sel", 32'(sel), 32'h0);
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      send_frame(8'h5A, 1'b1, 1'b1, 3);
      idle_cycles(2);

      check("final_scoreboard_empty", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "watchdog");
   end

endmodule
